alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/rr_arb2.sv | 40 ++++
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, legality check,
// FSM state encoding and flag bit positions.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int OP_W       = 5;
  localparam int NUM_REQ    = 2;
  localparam int ALU_FLAG_W = 4;
  localparam int RSP_FLAG_W = 5;

  // Opcodes understood by the shared ALU
  localparam logic [OP_W-1:0] OP_AND  = 5'b00000;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
  localparam logic [OP_W-1:0] OP_NOR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLT  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SLTU = 5'b01001;
  localparam logic [OP_W-1:0] OP_SRA  = 5'b01010;
  localparam logic [OP_W-1:0] OP_X0C  = 5'b01100;
  localparam logic [OP_W-1:0] OP_X0F  = 5'b01111;
  localparam logic [OP_W-1:0] OP_X1E  = 5'b11110;
  localparam logic [OP_W-1:0] OP_X1F  = 5'b11111;

  // Bit positions inside alu_flags / rsp_flags
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SET   = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ERR   = 4;

  // Response flags for an opcode the ALU does not implement: only err set
  localparam logic [RSP_FLAG_W-1:0] ERR_FLAGS = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for the opcodes the shared ALU actually implements
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_SRA) || (op == OP_X0C) || (op == OP_X0F) ||
           (op == OP_X1E) || (op == OP_X1F);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic with a last_grant register. With RR_EN set, a tie
// goes to the requester that was not served last; otherwise requester 0
// always wins a tie.
module rr_arb2
  import alu_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] accept,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant;

  // Grant selection from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ((RR_EN != 0) && (last_grant == 1'b0)) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was served; reset value 1 lets requester 0 win first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept[1]) begin
      last_grant <= 1'b1;
    end else if (accept[0]) begin
      last_grant <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the integer EX stage (requester 0)
// and the FP unit (requester 1). One operation in flight: IDLE accepts,
// EXEC drives the ALU for one cycle, RESP holds the captured result until
// the owner takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags
);

  state_t     state_q;
  state_t     state_d;
  logic       owner_q;
  logic [1:0] grant;
  logic [1:0] accept;
  logic       can_accept;

  rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Accept only in IDLE and never in a reset cycle
  assign can_accept = (state_q == ST_IDLE) && !reset;
  assign req_ready  = can_accept ? grant : 2'b00;
  assign accept     = req_valid & req_ready;
  assign rsp_valid  = ((state_q == ST_RESP) && !reset) ?
                      (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one EXEC cycle, then wait for the owner's rsp_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept != 2'b00) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready[owner_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winner's operation onto the ALU inputs; held until next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= 1'b0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (accept[1]) begin
      owner_q <= 1'b1;
      alu_op  <= req_op[9:5];
      alu_a   <= req_a[63:32];
      alu_b   <= req_b[63:32];
    end else if (accept[0]) begin
      owner_q <= 1'b0;
      alu_op  <= req_op[4:0];
      alu_a   <= req_a[31:0];
      alu_b   <= req_b[31:0];
    end
  end

  // Sample the ALU at the end of EXEC; unimplemented opcodes report err only
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (state_q == ST_EXEC) begin
      if (is_legal_op(alu_op)) begin
        rsp_result <= alu_result;
        rsp_flags  <= {1'b0, alu_flags};
      end else begin
        rsp_result <= '0;
        rsp_flags  <= ERR_FLAGS;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a round-robin instance and a
// fixed-priority instance, each driving its own reference ALU model.
module tb_alu_share_arbiter;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, rsp_ready, req_ready, rsp_valid;
  logic [9:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [4:0]  alu_op, rsp_flags;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_flags;

  logic [1:0]  fp_req_valid, fp_rsp_ready, fp_req_ready, fp_rsp_valid;
  logic [4:0]  fp_alu_op, fp_rsp_flags;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result, fp_rsp_result;
  logic [3:0]  fp_alu_flags;

  exp_t sb_q[$];
  exp_t sb_fp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags)
  );

  alu_share_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op(fp_alu_op),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_result(fp_alu_result),
    .alu_flags(fp_alu_flags), .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
    .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags)
  );

  // Reference ALU: returns {carry, overflow, set, zero, result}.
  // Unimplemented opcodes produce deliberate garbage.
  function automatic logic [35:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic c, v, s;
    wide = '0; r = '0; c = 1'b0; v = 1'b0; s = 1'b0;
    case (op)
      5'h00: r = a & b;
      5'h01: r = a | b;
      5'h02: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0]; c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'h03: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'h04: r = a ^ b;
      5'h05: r = ~(a | b);
      5'h06: r = a << b[4:0];
      5'h07: r = a >> b[4:0];
      5'h08: begin s = ($signed(a) < $signed(b)); r = {31'b0, s}; end
      5'h09: begin s = (a < b); r = {31'b0, s}; end
      5'h0A: r = $signed(a) >>> b[4:0];
      5'h0C: r = ~(a & b);
      5'h0F: r = {b[15:0], 16'h0000};
      5'h1E: r = a;
      5'h1F: r = b;
      default: begin r = 32'hDEADBEEF; c = 1'b1; v = 1'b1; s = 1'b1; end
    endcase
    return {c, v, s, (r == 32'd0), r};
  endfunction

  // Expected response {err, carry, overflow, set, zero, result}
  function automatic logic [36:0] expect_of(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    if (op <= 5'h0A || op == 5'h0C || op == 5'h0F || op == 5'h1E || op == 5'h1F)
      return {1'b0, alu_model(op, a, b)};
    return {1'b1, 36'd0};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);
  always_comb {fp_alu_flags, fp_alu_result} = alu_model(fp_alu_op, fp_alu_a, fp_alu_b);

  task automatic set_req(input int i, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[i*5 +: 5]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Leaves the bench at a falling edge with reset released
  task automatic apply_reset();
    reset = 1'b1; req_valid = 2'b00; fp_req_valid = 2'b00;
    rsp_ready = 2'b11; fp_rsp_ready = 2'b11;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    sb_q.delete(); sb_fp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; fp_req_valid = 2'b11; rsp_ready = 2'b11;
    fp_rsp_ready = 2'b11;
    set_req(0, 5'h02, 32'd1, 32'd2); set_req(1, 5'h02, 32'd3, 32'd4);
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (fp_req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_fp_req_ready: got %b want 00", fp_req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_flags !== 5'd0) begin
      n_bad++; $display("FAIL reset_rsp: got valid=%b result=%h flags=%b want 00/0/0", rsp_valid, rsp_result, rsp_flags); end
    n_cmp++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_bad++; $display("FAIL reset_alu_regs: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b); end
    reset = 1'b0; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00; fp_req_valid = 2'b00;
  endtask

  task automatic test_single();
    exp_t e;
    apply_reset();
    set_req(0, 5'b00010, 32'd5, 32'd7); req_valid = 2'b01; rsp_ready = 2'b01; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
    e.owner = 1'b0; {e.flg, e.res} = expect_of(5'b00010, 32'd5, 32'd7); sb_q.push_back(e);
    @(negedge clk); req_valid = 2'b00; #1;
    n_cmp++; if (rsp_valid !== 2'b00 || alu_op !== 5'h02 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      n_bad++; $display("FAIL single_exec: got valid=%b op=%h a=%h b=%h want 00/02/5/7", rsp_valid, alu_op, alu_a, alu_b); end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() == 0) begin n_bad++; $display("FAIL single_rsp: scoreboard empty"); end
    else begin
      e = sb_q.pop_front();
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_flags !== e.flg) begin
        n_bad++; $display("FAIL single_rsp: got valid=%b result=%h flags=%b want 01/%h/%b", rsp_valid, rsp_result, rsp_flags, e.res, e.flg); end
    end
    n_cmp++; if (rsp_result !== 32'd12 || rsp_flags !== 5'b00000) begin
      n_bad++; $display("FAIL single_value: got result=%0d flags=%b want 12/00000", rsp_result, rsp_flags); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 2'b00 || alu_op !== 5'h02 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      n_bad++; $display("FAIL single_hold: got valid=%b op=%h a=%h b=%h want 00/02/5/7", rsp_valid, alu_op, alu_a, alu_b); end
  endtask

  task automatic test_contention_rr();
    exp_t e;
    int grants[$];
    int got = 0;
    int upd = -1;
    int k;
    int want[4] = '{0, 1, 0, 1};
    apply_reset();
    set_req(0, 5'(($urandom_range(0, 10))), $urandom, $urandom);
    set_req(1, 5'(($urandom_range(0, 10))), $urandom, $urandom);
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      if (rsp_valid !== 2'b00) begin
        n_cmp++;
        if (sb_q.size() == 0) begin n_bad++; $display("FAIL rr_rsp: unexpected valid=%b", rsp_valid); end
        else begin
          e = sb_q.pop_front();
          if (rsp_valid !== (e.owner ? 2'b10 : 2'b01) || rsp_result !== e.res || rsp_flags !== e.flg) begin
            n_bad++; $display("FAIL rr_rsp: got valid=%b result=%h flags=%b want owner=%0d result=%h flags=%b",
                              rsp_valid, rsp_result, rsp_flags, e.owner, e.res, e.flg); end
        end
        got++;
      end
      if ((req_valid & req_ready) !== 2'b00) begin
        k = req_ready[1] ? 1 : 0;
        grants.push_back(k);
        e.owner = k[0];
        {e.flg, e.res} = expect_of(req_op[k*5 +: 5], req_a[k*32 +: 32], req_b[k*32 +: 32]);
        sb_q.push_back(e);
        upd = k;
      end
      @(negedge clk);
      if (upd >= 0) begin set_req(upd, 5'(($urandom_range(0, 10))), $urandom, $urandom); upd = -1; end
    end
    req_valid = 2'b00;
    n_cmp++; if (grants.size() != 4) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 4", grants.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (grants[i] != want[i]) begin n_bad++; $display("FAIL rr_grant_order[%0d]: got %0d want %0d", i, grants[i], want[i]); end
    end
  endtask

  task automatic test_contention_fixed();
    exp_t e;
    int grants[$];
    int got = 0;
    int upd = -1;
    int k;
    apply_reset();
    set_req(0, 5'h02, $urandom, $urandom);
    set_req(1, 5'h03, $urandom, $urandom);
    fp_req_valid = 2'b11;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      #1;
      if (fp_rsp_valid !== 2'b00) begin
        n_cmp++;
        if (sb_fp_q.size() == 0) begin n_bad++; $display("FAIL fixed_rsp: unexpected valid=%b", fp_rsp_valid); end
        else begin
          e = sb_fp_q.pop_front();
          if (fp_rsp_valid !== (e.owner ? 2'b10 : 2'b01) || fp_rsp_result !== e.res || fp_rsp_flags !== e.flg) begin
            n_bad++; $display("FAIL fixed_rsp: got valid=%b result=%h flags=%b want owner=%0d result=%h flags=%b",
                              fp_rsp_valid, fp_rsp_result, fp_rsp_flags, e.owner, e.res, e.flg); end
        end
        got++;
      end
      if ((fp_req_valid & fp_req_ready) !== 2'b00) begin
        k = fp_req_ready[1] ? 1 : 0;
        grants.push_back(k);
        e.owner = k[0];
        {e.flg, e.res} = expect_of(req_op[k*5 +: 5], req_a[k*32 +: 32], req_b[k*32 +: 32]);
        sb_fp_q.push_back(e);
        upd = k;
      end
      @(negedge clk);
      if (upd >= 0) begin set_req(upd, 5'(($urandom_range(0, 10))), $urandom, $urandom); upd = -1; end
    end
    fp_req_valid = 2'b00;
    n_cmp++; if (grants.size() != 3) begin n_bad++; $display("FAIL fixed_grant_count: got %0d want 3", grants.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (grants[i] != 0) begin n_bad++; $display("FAIL fixed_grant_order[%0d]: got %0d want 0", i, grants[i]); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    apply_reset();
    set_req(0, 5'b00011, 32'd9, 32'd9); set_req(1, 5'h02, 32'd1, 32'd1);
    req_valid = 2'b01; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_accept: got %b want 01", req_ready); end
    e.owner = 1'b0; {e.flg, e.res} = expect_of(5'b00011, 32'd9, 32'd9); sb_q.push_back(e);
    @(negedge clk); req_valid = 2'b11; rsp_ready = 2'b00; #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_exec_ready: got %b want 00", req_ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rsp_ready = (i < 2) ? 2'b00 : 2'b10;
      #1;
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_flags !== 5'b00001 || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b result=%h flags=%b ready=%b want 01/0/00001/00",
                          i, rsp_valid, rsp_result, rsp_flags, req_ready); end
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b01; #1;
    n_cmp++;
    if (sb_q.size() == 0) begin n_bad++; $display("FAIL bp_rsp: scoreboard empty"); end
    else begin
      e = sb_q.pop_front();
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_flags !== e.flg) begin
        n_bad++; $display("FAIL bp_rsp: got valid=%b result=%h flags=%b want 01/%h/%b", rsp_valid, rsp_result, rsp_flags, e.res, e.flg); end
    end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL bp_release: got valid=%b want 00", rsp_valid); end
  endtask

  // Single-requester operations on requester 1: illegal ops, legal edges, slt boundary
  task automatic test_ops();
    exp_t e;
    logic [4:0]  ops[6] = '{5'b01101, 5'b01011, 5'b10000, 5'b11111, 5'b01000, 5'b01000};
    logic [31:0] as[6]  = '{32'h1234, 32'h55, 32'h7, 32'hA5A5, 32'hFFFFFFFF, 32'd1};
    logic [31:0] bs[6]  = '{32'h4321, 32'h66, 32'h8, 32'h5A5A, 32'd1, 32'hFFFFFFFF};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(1, ops[i], as[i], bs[i]); req_valid = 2'b10; rsp_ready = 2'b10; #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL ops_accept[%0d]: got %b want 10", i, req_ready); end
      e.owner = 1'b1; {e.flg, e.res} = expect_of(ops[i], as[i], bs[i]); sb_q.push_back(e);
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); #1;
      n_cmp++;
      if (sb_q.size() == 0) begin n_bad++; $display("FAIL ops_rsp[%0d]: scoreboard empty", i); end
      else begin
        e = sb_q.pop_front();
        if (rsp_valid !== 2'b10 || rsp_result !== e.res || rsp_flags !== e.flg) begin
          n_bad++; $display("FAIL ops_rsp[%0d]: op=%b got valid=%b result=%h flags=%b want 10/%h/%b",
                            i, ops[i], rsp_valid, rsp_result, rsp_flags, e.res, e.flg); end
      end
      if (i == 0) begin
        n_cmp++; if (rsp_flags !== 5'b10000 || rsp_result !== 32'd0) begin
          n_bad++; $display("FAIL illegal_op: got result=%h flags=%b want 0/10000", rsp_result, rsp_flags); end
      end
      if (i == 4) begin
        n_cmp++; if (rsp_result !== 32'd1 || rsp_flags[1] !== 1'b1) begin
          n_bad++; $display("FAIL slt_boundary: got result=%h set=%b want 1/1", rsp_result, rsp_flags[1]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    set_req(0, 5'h02, 32'd1, 32'd2); set_req(1, 5'h04, 32'hF0, 32'h0F);
    req_valid = 2'b01; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_accept: got %b want 01", req_ready); end
    e.owner = 1'b0; {e.flg, e.res} = expect_of(5'h02, 32'd1, 32'd2); sb_q.push_back(e);
    @(negedge clk); reset = 1'b1; req_valid = 2'b11; sb_q.delete();
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_abort: got valid=%b want 00", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_next_grant: got %b want 01", req_ready); end
    e.owner = 1'b0; {e.flg, e.res} = expect_of(5'h02, 32'd1, 32'd2); sb_q.push_back(e);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() == 0) begin n_bad++; $display("FAIL mid_rsp: scoreboard empty"); end
    else begin
      e = sb_q.pop_front();
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_flags !== e.flg) begin
        n_bad++; $display("FAIL mid_rsp: got valid=%b result=%h flags=%b want 01/%h/%b", rsp_valid, rsp_result, rsp_flags, e.res, e.flg); end
    end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 2'b00 || sb_q.size() != 0) begin
      n_bad++; $display("FAIL mid_quiet: got valid=%b pending=%0d want 00/0", rsp_valid, sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acc[$];
    int got = 0;
    int upd = 0;
    apply_reset();
    set_req(0, 5'(($urandom_range(0, 10))), $urandom, $urandom);
    req_valid = 2'b01;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      if (rsp_valid !== 2'b00) begin
        n_cmp++;
        if (sb_q.size() == 0 || got >= acc.size()) begin n_bad++; $display("FAIL b2b_rsp: unexpected valid=%b", rsp_valid); end
        else begin
          e = sb_q.pop_front();
          if (rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_flags !== e.flg || cyc - acc[got] != 2) begin
            n_bad++; $display("FAIL b2b_rsp: got valid=%b result=%h flags=%b latency=%0d want 01/%h/%b/2",
                              rsp_valid, rsp_result, rsp_flags, cyc - acc[got], e.res, e.flg); end
        end
        got++;
      end
      if ((req_valid & req_ready) !== 2'b00) begin
        acc.push_back(cyc);
        e.owner = 1'b0; {e.flg, e.res} = expect_of(req_op[4:0], req_a[31:0], req_b[31:0]);
        sb_q.push_back(e);
        upd = 1;
      end
      @(negedge clk);
      if (upd != 0) begin set_req(0, 5'(($urandom_range(0, 10))), $urandom, $urandom); upd = 0; end
    end
    req_valid = 2'b00;
    n_cmp++; if (got != 4 || acc.size() < 4) begin n_bad++; $display("FAIL b2b_count: got %0d rsp %0d acc want 4", got, acc.size()); end
    else for (int i = 1; i < 4; i++) begin
      n_cmp++; if (acc[i] - acc[i-1] != 3) begin n_bad++; $display("FAIL b2b_interval[%0d]: got %0d want 3", i, acc[i] - acc[i-1]); end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; fp_req_valid = 2'b00;
    rsp_ready = 2'b11; fp_rsp_ready = 2'b11;
    req_op = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_contention_rr();
    test_contention_fixed();
    test_backpressure();
    test_ops();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
